// File: rtl/ysyx_24090003_mem_arbiter_if.sv
// ysyx_24090003_mem_arbiter_if: IFU, LSU and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; the master modport drives the masters and models memory.
interface ysyx_24090003_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_ifu_req;
  logic [ADDR_W-1:0] i_ifu_addr;
  logic              o_ifu_gnt;
  logic              o_ifu_rvalid;
  logic [DATA_W-1:0] o_ifu_rdata;
  logic              i_lsu_req;
  logic              i_lsu_wen;
  logic [ADDR_W-1:0] i_lsu_addr;
  logic [DATA_W-1:0] i_lsu_wdata;
  logic [DATA_W/8-1:0] i_lsu_wmask;
  logic              o_lsu_gnt;
  logic              o_lsu_rvalid;
  logic [DATA_W-1:0] o_lsu_rdata;
  logic              o_err;
  logic              o_mem_req;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W/8-1:0] o_mem_wmask;
  logic              i_mem_ready;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;
  modport slave (
    input  i_ifu_req, i_ifu_addr, i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
           i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata, o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_err,
           o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask
  );
  modport master (
    output i_ifu_req, i_ifu_addr, i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
           i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata, o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_err,
           o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask
  );
endinterface

// File: rtl/ysyx_24090003_mem_arbiter.sv
// ysyx_24090003_mem_arbiter: shares one memory port between IFU and LSU, one transaction at a time, with a wait watchdog.
// Define YSYX_24090003_ARB_RR_EN for round-robin tie breaking; otherwise LSU has fixed priority.
module ysyx_24090003_mem_arbiter #(
  parameter int MAX_WAIT = 255,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input logic i_clk,
  input logic i_rst,
  ysyx_24090003_mem_arbiter_if.slave bus
);
  localparam int MW = DATA_W / 8;
  localparam int CW = MAX_WAIT > 1 ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_WAIT == 0 ? 0 : MAX_WAIT - 1);
  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d, wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MW-1:0]     wmask_q, wmask_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ifu_rv_q, ifu_rv_d, lsu_rv_q, lsu_rv_d, err_q, err_d;
  logic [DATA_W-1:0] ifu_rd_q, ifu_rd_d, lsu_rd_q, lsu_rd_d;
  logic              pick_lsu, grant, done, tmo, mreq;
`ifdef YSYX_24090003_ARB_RR_EN
  assign pick_lsu = bus.i_lsu_req && (!bus.i_ifu_req || !last_q);
`else
  assign pick_lsu = bus.i_lsu_req;
`endif
  assign grant = state_q == IDLE && (bus.i_ifu_req || bus.i_lsu_req);
  assign done  = state_q == WAIT && bus.i_mem_rvalid;
  // timeout fires on the edge where the counter would reach MAX_WAIT; a completion in that cycle wins
  assign tmo   = MAX_WAIT != 0 && state_q != IDLE && cnt_q == LIM && !done;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q + CW'(state_q != IDLE && cnt_q != SAT);
    ifu_rv_d = 1'b0;
    lsu_rv_d = 1'b0;
    err_d    = tmo;
    ifu_rd_d = ifu_rd_q;
    lsu_rd_d = lsu_rd_q;
    if (grant) begin
      state_d = REQ;
      owner_d = pick_lsu;
      last_d  = pick_lsu;
      wen_d   = pick_lsu && bus.i_lsu_wen;
      addr_d  = pick_lsu ? bus.i_lsu_addr : bus.i_ifu_addr;
      wdata_d = pick_lsu ? bus.i_lsu_wdata : '0;
      wmask_d = pick_lsu ? bus.i_lsu_wmask : '0;
      cnt_d   = '0;
    end else if (done || tmo) begin
      state_d  = IDLE;
      ifu_rv_d = !owner_q;
      lsu_rv_d = owner_q;
      ifu_rd_d = owner_q ? ifu_rd_q : (tmo ? '0 : bus.i_mem_rdata);
      lsu_rd_d = owner_q ? (tmo ? '0 : bus.i_mem_rdata) : lsu_rd_q;
    end else if (state_q == REQ && bus.i_mem_ready) begin
      state_d = WAIT;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      cnt_q    <= '0;
      ifu_rv_q <= 1'b0;
      lsu_rv_q <= 1'b0;
      err_q    <= 1'b0;
      ifu_rd_q <= '0;
      lsu_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      cnt_q    <= cnt_d;
      ifu_rv_q <= ifu_rv_d;
      lsu_rv_q <= lsu_rv_d;
      err_q    <= err_d;
      ifu_rd_q <= ifu_rd_d;
      lsu_rd_q <= lsu_rd_d;
    end
  end
  // every output is forced low while reset is held, even before the state register clears
  assign mreq             = !i_rst && state_q == REQ;
  assign bus.o_ifu_gnt    = !i_rst && grant && !pick_lsu;
  assign bus.o_lsu_gnt    = !i_rst && grant && pick_lsu;
  assign bus.o_ifu_rvalid = !i_rst && ifu_rv_q;
  assign bus.o_lsu_rvalid = !i_rst && lsu_rv_q;
  assign bus.o_err        = !i_rst && err_q;
  assign bus.o_ifu_rdata  = i_rst ? '0 : ifu_rd_q;
  assign bus.o_lsu_rdata  = i_rst ? '0 : lsu_rd_q;
  assign bus.o_mem_req    = mreq;
  assign bus.o_mem_wen    = mreq && wen_q;
  assign bus.o_mem_addr   = mreq ? addr_q : '0;
  assign bus.o_mem_wdata  = mreq ? wdata_q : '0;
  assign bus.o_mem_wmask  = mreq ? wmask_q : '0;
endmodule
